// File: rtl/multdiv_seq.sv
// Iterative signed multiply (Booth radix-2) / divide (restoring, on magnitudes) sequencer.
// One iteration per clock for WIDTH clocks, then a single-cycle ready strobe in DONE.
module multdiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

  localparam int PW = 2*WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  // Operand conditioning at start
  logic             a_neg, b_neg, b_zero, div_ovf;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg   = data_operandA[WIDTH-1];
  assign b_neg   = data_operandB[WIDTH-1];
  assign a_mag   = a_neg ? (-data_operandA) : data_operandA;
  assign b_mag   = b_neg ? (-data_operandB) : data_operandB;
  assign b_zero  = (data_operandB == '0);
  assign div_ovf = (data_operandA == MIN_INT) && (&data_operandB);

  // Booth step: the accumulator is widened by one bit so that subtracting MIN_INT cannot wrap.
  logic [WIDTH:0]   acc_ext, m_ext, booth_sum;
  logic [PW-1:0]    p_booth;
  logic [WIDTH:0]   prod_hi;
  logic             mult_ovf;

  assign acc_ext = {p_q[PW-1], p_q[PW-1:WIDTH+1]};
  assign m_ext   = {m_q[WIDTH-1], m_q};

  always_comb begin
    booth_sum = acc_ext;
    case (p_q[1:0])
      2'b01:   booth_sum = acc_ext + m_ext;
      2'b10:   booth_sum = acc_ext - m_ext;
      default: booth_sum = acc_ext;
    endcase
  end

  assign p_booth  = {booth_sum, p_q[WIDTH:1]};
  assign prod_hi  = p_booth[PW-1:WIDTH];
  assign mult_ovf = !((&prod_hi) || !(|prod_hi));

  // Restoring divide step: upper W+1 bits hold the partial remainder, lower W bits the quotient.
  logic [WIDTH:0]   div_shift, div_sub, div_rem;
  logic             div_ge;
  logic [WIDTH-1:0] quo_next, div_res;
  logic [PW-1:0]    p_div;

  assign div_shift = {p_q[PW-2:WIDTH], p_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, m_q});
  assign div_sub   = div_shift - {1'b0, m_q};
  assign div_rem   = div_ge ? div_sub : div_shift;
  assign quo_next  = {p_q[WIDTH-2:0], div_ge};
  assign p_div     = {div_rem, quo_next};
  assign div_res   = neg_q ? (-quo_next) : quo_next;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    p_d      = p_q;
    m_d      = m_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    exc_d    = exc_q;

    // A start in any state wins; multiply has priority over divide.
    if (ctrl_mult) begin
      state_d = MULT;
      count_d = '0;
      p_d     = {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
      m_d     = data_operandA;
    end else if (ctrl_div) begin
      count_d = '0;
      if (b_zero) begin
        state_d  = DONE;
        result_d = '0;
        exc_d    = 1'b1;
      end else begin
        state_d = DIV;
        p_d     = {{(WIDTH+1){1'b0}}, a_mag};
        m_d     = b_mag;
        neg_d   = a_neg ^ b_neg;
        ovf_d   = div_ovf;
      end
    end else begin
      case (state_q)
        MULT: begin
          p_d = p_booth;
          if (count_q == LAST) begin
            state_d  = DONE;
            count_d  = '0;
            result_d = p_booth[WIDTH:1];
            exc_d    = mult_ovf;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        DIV: begin
          p_d = p_div;
          if (count_q == LAST) begin
            state_d  = DONE;
            count_d  = '0;
            result_d = div_res;
            exc_d    = ovf_q;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      count_q  <= '0;
      p_q      <= '0;
      m_q      <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      p_q      <= p_d;
      m_q      <= m_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q == MULT) || (state_q == DIV);

endmodule

// File: tb/tb_multdiv_seq.sv
// Scoreboard bench for multdiv_seq: expected result/exception/strobe cycle queued at start,
// compared when the ready strobe appears.
module tb_multdiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clr;
  logic         ctrl_mult, ctrl_div;
  logic [W-1:0] data_operandA, data_operandB;
  logic [W-1:0] data_result;
  logic         data_exception, data_resultRDY, busy;

  multdiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk            (clk),
    .clr            (clr),
    .ctrl_mult      (ctrl_mult),
    .ctrl_div       (ctrl_div),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         exc;
    int           cyc;
  } exp_t;

  exp_t scb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain wide signed arithmetic, returns {exc, result}
  function automatic logic [W:0] model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0]  sa, sbv, p;
    logic signed [W-1:0] qa, qb, q;
    if (m) begin
      sa  = {{32{a[W-1]}}, a};
      sbv = {{32{b[W-1]}}, b};
      p   = sa * sbv;
      return {(p[63:31] != {33{1'b0}}) && (p[63:31] != {33{1'b1}}), p[W-1:0]};
    end
    if (b == '0) return {1'b1, {W{1'b0}}};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    qa = a;
    qb = b;
    q  = qa / qb;
    return {1'b0, q};
  endfunction

  always @(negedge clk) begin
    if (scb.size() > 0 && scb[0].cyc <= cyc) begin
      exp_t e;
      e = scb.pop_front();
      if (data_resultRDY === 1'b1) begin
        check("result", data_result, e.res);
        check("exception", data_exception, e.exc);
      end else begin
        check("rdy_missing", data_resultRDY, 1);
      end
    end else if (data_resultRDY === 1'b1) begin
      check("spurious_rdy", data_resultRDY, 0);
    end
  end

  task automatic start_op(input logic m, input logic d, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er, input logic ee);
    exp_t e;
    @(negedge clk);
    if (scb.size() > 0 && scb[0].cyc > cyc) void'(scb.pop_front());
    ctrl_mult     = m;
    ctrl_div      = d;
    data_operandA = a;
    data_operandB = b;
    e.res = er;
    e.exc = ee;
    e.cyc = cyc + 1 + ((d && !m && b == '0) ? 0 : W);
    scb.push_back(e);
    @(negedge clk);
    ctrl_mult     = 1'b0;
    ctrl_div      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && scb.size() > 0; k++) @(negedge clk);
    check("drain", scb.size(), 0);
  endtask

  task automatic do_clr(input int n);
    @(negedge clk);
    clr = 1'b1;
    scb.delete();
    repeat (n) @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0]   r;
    logic [W-1:0] a, b;
    logic         m;
    int           rdy_seen;
    clr = 1'b1;
    ctrl_mult = 1'b0;
    ctrl_div = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clk);
    check("rst_result", data_result, 0);
    check("rst_exc", data_exception, 0);
    check("rst_rdy", data_resultRDY, 0);
    check("rst_busy", busy, 0);
    clr = 1'b0;
    rdy_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (data_resultRDY !== 1'b0 || busy !== 1'b0) rdy_seen++;
    end
    check("idle_quiet", rdy_seen, 0);

    // 7 * -6 with busy window and hold checks
    start_op(1, 0, 32'd7, -32'sd6, 32'hFFFF_FFD6, 0);
    check("busy_first", busy, 1);
    repeat (W-1) @(negedge clk);
    check("busy_last", busy, 1);
    @(negedge clk);
    check("busy_done", busy, 0);
    repeat (5) @(negedge clk);
    check("hold_result", data_result, 32'hFFFF_FFD6);
    check("hold_rdy_low", data_resultRDY, 0);

    start_op(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1); drain();
    start_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 0); drain();
    start_op(1, 0, 32'h8000_0000, 32'h8000_0000, 32'h0, 1); drain();
    start_op(0, 1, -32'sd7, 32'd2, 32'hFFFF_FFFD, 0);       drain();
    start_op(0, 1, 32'd5, 32'd0, 32'h0, 1);                 drain();
    start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1); drain();

    // abort: mult at T, div at T+10 replaces it
    start_op(1, 0, 32'd3, 32'd4, 32'd12, 0);
    repeat (8) @(negedge clk);
    start_op(0, 1, 32'd100, 32'd7, 32'd14, 0);
    drain();

    start_op(1, 1, 32'd3, 32'd4, 32'd12, 0); drain();

    // clr mid-operation: no strobe, result cleared
    start_op(1, 0, 32'd9, 32'd9, 32'd81, 0);
    repeat (3) @(negedge clk);
    do_clr(1);
    repeat (40) @(negedge clk);
    check("clr_result", data_result, 0);
    check("clr_busy", busy, 0);
    start_op(1, 0, 32'd2, 32'd3, 32'd6, 0); drain();

    for (int i = 0; i < 24; i++) begin
      m = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 20) - 10;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       b = 32'hFFFF_FFFF;
        1:       b = $urandom_range(0, 6) - 3;
        2:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      r = model(m, a, b);
      start_op(m, !m, a, b, r[W-1:0], r[W]);
      drain();
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
